// File: rtl/filt_scratch_read.sv
// Filter scratchpad replay: reads the stored filter once per output window,
// tags data valid/last for the MAC and pulses done after the final window.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 latch filt_len/mode/num_windows and (re)start replay
//   filt_ready            load stage idle, scratchpad stable
//   filt_len, mode        filter length; mode==1 single, else dual (2*filt_len)
//   num_windows           number of full filter replays
//   mac_ready             MAC accepts a word this cycle (gates ren directly)
//   filt_raddr            scratchpad read address
//   filt_scratch_ren      scratchpad read enable
//   filt_valid/filt_last  read data valid / last word of a window
//   busy, done            replay in progress / one-cycle completion pulse
//
// Build option: FILT_SCRATCH_DUAL_EN enables the dual-filter length doubling.
// Without it, mode is ignored and the effective length is filt_len.
module filt_scratch_read #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16,
  parameter int WIN_LEN       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                filt_ready,
  input  logic [ADDR_LEN-1:0] filt_len,
  input  logic [1:0]          mode,
  input  logic [WIN_LEN-1:0]  num_windows,
  input  logic                mac_ready,
  output logic [ADDR_LEN-1:0] filt_raddr,
  output logic                filt_scratch_ren,
  output logic                filt_valid,
  output logic                filt_last,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int unused_width = SCRATCH_WIDTH;

  logic [1:0]          state_q, state_d;
  logic [ADDR_LEN-1:0] raddr_q, raddr_d;
  logic [ADDR_LEN-1:0] len_q, len_d;
  logic [WIN_LEN-1:0]  win_q, win_d;
  logic [WIN_LEN-1:0]  nwin_q, nwin_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic [ADDR_LEN-1:0] len_in;
  logic [ADDR_LEN-1:0] end_addr;
  logic                ren;
  logic                at_end;
  logic                last_win;
  logic                empty;

`ifdef FILT_SCRATCH_DUAL_EN
  // Doubled length wraps at ADDR_LEN bits; caller keeps it in range.
  assign len_in = (mode == 2'd1) ? filt_len
                                 : {filt_len[ADDR_LEN-2:0], 1'b0};
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign len_in = filt_len;
`endif

  assign end_addr = len_q - ADDR_LEN'(1);
  assign at_end   = (raddr_q == end_addr);
  assign last_win = (win_q == nwin_q - WIN_LEN'(1));
  assign empty    = (len_q == '0) || (nwin_q == '0);

  // Read enable follows mac_ready combinationally so a stall costs no beat.
  assign ren = (state_q == S_READ) && mac_ready;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    win_d   = win_q;
    len_d   = len_q;
    nwin_d  = nwin_q;
    valid_d = ren;
    last_d  = ren && at_end;

    unique case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (filt_ready) begin
          state_d = empty ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (ren) begin
          if (at_end) begin
            raddr_d = '0;
            win_d   = win_q + WIN_LEN'(1);
            if (last_win) begin
              state_d = S_DRAIN;
            end
          end else begin
            raddr_d = raddr_q + ADDR_LEN'(1);
          end
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Restart from any state; a read issued this cycle still returns data.
    if (start) begin
      state_d = S_WAIT;
      raddr_d = '0;
      win_d   = '0;
      len_d   = len_in;
      nwin_d  = num_windows;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      win_q   <= '0;
      len_q   <= '0;
      nwin_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      win_q   <= win_d;
      len_q   <= len_d;
      nwin_q  <= nwin_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ren) begin
      assert (32'(raddr_q) < SCRATCH_DEPTH)
        else $error("read address beyond scratchpad");
    end
  end

  assign filt_raddr       = raddr_q;
  assign filt_scratch_ren = ren;
  assign filt_valid       = valid_q;
  assign filt_last        = last_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DRAIN);

endmodule

// File: tb/tb_filt_scratch_read.sv
// Directed bench for filt_scratch_read.
// Per-cycle masks drive inputs; observed per-cycle traces checked against hand values.
module tb_filt_scratch_read;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       filt_ready;
  logic [3:0] filt_len;
  logic [1:0] mode;
  logic [7:0] num_windows;
  logic       mac_ready;
  logic [3:0] filt_raddr;
  logic       filt_scratch_ren;
  logic       filt_valid;
  logic       filt_last;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [15:0] ren_m, val_m, last_m, done_m, busy_m;
  logic [31:0] addr_pk;
  logic [3:0]  ra_k [16];

  filt_scratch_read dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .filt_ready       (filt_ready),
    .filt_len         (filt_len),
    .mode             (mode),
    .num_windows      (num_windows),
    .mac_ready        (mac_ready),
    .filt_raddr       (filt_raddr),
    .filt_scratch_ren (filt_scratch_ren),
    .filt_valid       (filt_valid),
    .filt_last        (filt_last),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle k=0 is the first cycle the masks apply (normally the start cycle).
  task automatic run(input logic [15:0] sm, input logic [15:0] stl,
                     input logic [15:0] frl, input logic [15:0] rm);
    ren_m = '0; val_m = '0; last_m = '0;
    done_m = '0; busy_m = '0; addr_pk = '0;
    for (int k = 0; k < 16; k++) begin
      start      = sm[k];
      mac_ready  = !stl[k];
      filt_ready = !frl[k];
      rst        = rm[k];
      #1;
      if (filt_scratch_ren) addr_pk = {addr_pk[27:0], filt_raddr};
      ren_m[k]  = filt_scratch_ren;
      val_m[k]  = filt_valid;
      last_m[k] = filt_last;
      done_m[k] = done;
      busy_m[k] = busy;
      ra_k[k]   = filt_raddr;
      @(posedge clk);
      #1;
    end
    start = 1'b0; mac_ready = 1'b1; filt_ready = 1'b1; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; filt_ready = 1'b1; mac_ready = 1'b1;
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_raddr", 32'(filt_raddr), 32'd0);
    chk("rst_ren",   32'(filt_scratch_ren), 32'd0);
    chk("rst_valid", 32'(filt_valid), 32'd0);
    chk("rst_last",  32'(filt_last), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    @(posedge clk);
    #1;

    // Basic: L=3, two windows
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd2;
    run(16'h0001, 16'h0, 16'h0, 16'h0);
    chk("t1_ren",   32'(ren_m),  32'h00FC);
    chk("t1_addr",  addr_pk,     32'h0001_2012);
    chk("t1_valid", 32'(val_m),  32'h01F8);
    chk("t1_last",  32'(last_m), 32'h0120);
    chk("t1_done",  32'(done_m), 32'h0100);
    chk("t1_busy",  32'(busy_m), 32'h01FE);

    // Dual mode
    filt_len = 4'd3; mode = 2'd0; num_windows = 8'd1;
    run(16'h0001, 16'h0, 16'h0, 16'h0);
`ifdef FILT_SCRATCH_DUAL_EN
    chk("t2_ren",  32'(ren_m),  32'h00FC);
    chk("t2_addr", addr_pk,     32'h0001_2345);
    chk("t2_last", 32'(last_m), 32'h0100);
    chk("t2_done", 32'(done_m), 32'h0100);
`else
    chk("t2_ren",  32'(ren_m),  32'h001C);
    chk("t2_addr", addr_pk,     32'h0000_0012);
    chk("t2_last", 32'(last_m), 32'h0020);
    chk("t2_done", 32'(done_m), 32'h0020);
`endif

    // Stall two cycles while raddr=1
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd2;
    run(16'h0001, 16'h0018, 16'h0, 16'h0);
    chk("t3_ren",   32'(ren_m),  32'h03E4);
    chk("t3_addr",  addr_pk,     32'h0001_2012);
    chk("t3_hold",  32'(ra_k[4]), 32'd1);
    chk("t3_valid", 32'(val_m),  32'h07C8);
    chk("t3_last",  32'(last_m), 32'h0480);
    chk("t3_done",  32'(done_m), 32'h0400);
    chk("t3_busy",  32'(busy_m), 32'h07FE);

    // filt_ready low for 5 cycles after start
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd1;
    run(16'h0001, 16'h0, 16'h003F, 16'h0);
    chk("t4_ren",  32'(ren_m),  32'h0380);
    chk("t4_done", 32'(done_m), 32'h0400);
    chk("t4_busy", 32'(busy_m), 32'h07FE);

    // Restart at raddr=2
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd2;
    run(16'h0011, 16'h0, 16'h0, 16'h0);
    chk("t5_ren",   32'(ren_m),  32'h0FDC);
    chk("t5_raddr", 32'(ra_k[5]), 32'd0);
    chk("t5_valid", 32'(val_m),  32'h1FB8);
    chk("t5_done",  32'(done_m), 32'h1000);
    chk("t5_busy",  32'(busy_m), 32'h1FFE);

    // num_windows = 0
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd0;
    run(16'h0001, 16'h0, 16'h0, 16'h0);
    chk("t6_ren",   32'(ren_m),  32'h0000);
    chk("t6_valid", 32'(val_m),  32'h0000);
    chk("t6_done",  32'(done_m), 32'h0004);
    chk("t6_busy",  32'(busy_m), 32'h0006);

    // filt_len = 0
    filt_len = 4'd0; mode = 2'd1; num_windows = 8'd2;
    run(16'h0001, 16'h0, 16'h0, 16'h0);
    chk("t7_ren",  32'(ren_m),  32'h0000);
    chk("t7_done", 32'(done_m), 32'h0004);
    chk("t7_busy", 32'(busy_m), 32'h0006);

    // Reset mid-READ
    filt_len = 4'd3; mode = 2'd1; num_windows = 8'd2;
    run(16'h0001, 16'h0, 16'h0, 16'h0010);
    chk("t8_ren",   32'(ren_m),  32'h001C);
    chk("t8_valid", 32'(val_m),  32'h0018);
    chk("t8_busy",  32'(busy_m), 32'h001E);
    chk("t8_raddr", 32'(ra_k[5]), 32'd0);
    chk("t8_last",  32'(last_m), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
